// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_if
//  Purpose  : Bundles the requester-side and RAM-side signals of the RAM
//             arbiter.
//             slave  modport - arbiter view (requests in, RAM strobes out)
//             master modport - requester/RAM-model view (the opposite side)
//  Signals  : req/wen/addr/wdata  requester inputs (addr/wdata packed, i*W)
//             gnt/done/err        one-hot per-requester status
//             rdata               returned read data
//             ramREN/ramWEN/ramaddr/ramstore  RAM port drive
//             ramload/ramstate    RAM port response
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    wen;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [DW-1:0]      rdata;
  logic               ramREN;
  logic               ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore;
  logic [DW-1:0]      ramload;
  logic [1:0]         ramstate;

  modport slave (
    input  req, wen, addr, wdata, ramload, ramstate,
    output gnt, done, err, rdata, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output req, wen, addr, wdata, ramload, ramstate,
    input  gnt, done, err, rdata, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one RAM port among NREQ cache requesters. A winner is
//             picked from the high-priority class (PRIO_MASK) if any of
//             those request, otherwise from all requesters, round-robin from
//             rr_ptr. The grant is held for the whole transfer; done/err are
//             single-cycle pulses to the winner. A watchdog aborts transfers
//             that last TIMEOUT cycles (0 disables it).
//  Ports    : clk_i  - clock, rising edge
//             rst_i  - synchronous active-high reset
//             bus    - ram_arbiter_if.slave (requester and RAM signals)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int              NREQ      = 4,
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [NREQ-1:0] PRIO_MASK = 4'b1010,
  parameter int              TIMEOUT   = 64
) (
  input  wire logic    clk_i,
  input  wire logic    rst_i,
  ram_arbiter_if.slave bus
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Watchdog value seen on the TIMEOUT-th XFER cycle (wdog starts at 0).
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   rr_q;
  logic [WDW-1:0]  wdog_q;
  logic [NREQ-1:0] gnt_q;

  logic [NREQ-1:0] cand_d;
  logic [IW-1:0]   win_d;
  logic            found_d;
  logic            xfer_d;
  logic            is_acc_d;
  logic            is_err_d;
  logic            is_to_d;
  logic            exit_d;
  logic [NREQ-1:0] win_oh_d;
  logic [IW-1:0]   rr_next_d;

  // Candidate selection: scan from rr_q upward with wraparound.
  always_comb begin
    cand_d = bus.req & PRIO_MASK;
    if (cand_d == '0) begin
      cand_d = bus.req;
    end
    win_d   = rr_q;
    found_d = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_d && cand_d[(int'(rr_q) + k) % NREQ]) begin
        found_d = 1'b1;
        win_d   = IW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    xfer_d    = (state_q == XFER);
    is_acc_d  = (bus.ramstate == RS_ACCESS);
    is_err_d  = (bus.ramstate == RS_ERROR);
    is_to_d   = (TIMEOUT != 0) && (wdog_q == WD_LAST);
    exit_d    = is_acc_d || is_err_d || is_to_d || !bus.req[win_q];
    win_oh_d  = NREQ'(1) << win_q;
    rr_next_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
  end

  // done/err are suppressed in a reset cycle so a reset mid-transfer never
  // produces a completion pulse.
  assign bus.gnt      = gnt_q;
  assign bus.done     = (xfer_d && !rst_i && is_acc_d) ? win_oh_d : '0;
  assign bus.err      = (xfer_d && !rst_i && !is_acc_d && (is_err_d || is_to_d))
                        ? win_oh_d : '0;
  assign bus.rdata    = bus.ramload;
  assign bus.ramREN   = xfer_d && !bus.wen[win_q];
  assign bus.ramWEN   = xfer_d &&  bus.wen[win_q];
  assign bus.ramaddr  = xfer_d ? bus.addr[win_q*AW +: AW]  : '0;
  assign bus.ramstore = xfer_d ? bus.wdata[win_q*DW +: DW] : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      rr_q    <= '0;
      wdog_q  <= '0;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wdog_q <= '0;
          if (bus.req != '0) begin
            win_q   <= win_d;
            gnt_q   <= NREQ'(1) << win_d;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (exit_d) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            rr_q    <= rr_next_d;
            wdog_q  <= '0;
          end else begin
            wdog_q  <= wdog_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Directed self-checking bench for ram_arbiter. A second instance
//             with PRIO_MASK=0 shows plain round-robin ordering.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.NREQ(4), .AW(32), .DW(32)) bus  ();
  ram_arbiter_if #(.NREQ(4), .AW(32), .DW(32)) bus0 ();

  ram_arbiter #(.NREQ(4), .AW(32), .DW(32), .PRIO_MASK(4'b1010), .TIMEOUT(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  ram_arbiter #(.NREQ(4), .AW(32), .DW(32), .PRIO_MASK(4'b0000), .TIMEOUT(64)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs are then driven and
  // outputs checked 1 time unit later, well away from either edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req = '0;  bus.wen = '0;  bus.addr = '0;  bus.wdata = '0;
    bus.ramload = '0;  bus.ramstate = 2'b00;
    bus0.req = '0; bus0.wen = '0; bus0.addr = '0; bus0.wdata = '0;
    bus0.ramload = '0; bus0.ramstate = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  logic [3:0] exp_gnt [8];

  initial begin
    idle_inputs();
    do_reset();
    #1;
    chk("reset_gnt",     bus.gnt,     64'h0);
    chk("reset_done",    bus.done,    64'h0);
    chk("reset_err",     bus.err,     64'h0);
    chk("reset_ren_wen", {bus.ramREN, bus.ramWEN}, 64'h0);
    chk("reset_addr",    bus.ramaddr, 64'h0);

    // T1: read by requester 1, ACCESS on 3rd XFER cycle
    bus.req = 4'b0010; bus.addr[1*32 +: 32] = 32'h100;
    #1 chk("t1_idle_gnt", bus.gnt, 64'h0);
    cyc(); bus.ramstate = 2'b01;
    #1 chk("t1_gnt",    bus.gnt,     64'h2);
    chk("t1_ren",       {bus.ramREN, bus.ramWEN}, 64'h2);
    chk("t1_addr",      bus.ramaddr, 64'h100);
    chk("t1_nodone",    bus.done,    64'h0);
    cyc();
    #1 chk("t1_x2_nodone", bus.done, 64'h0);
    cyc(); bus.ramstate = 2'b10; bus.ramload = 32'hDEADBEEF;
    #1 chk("t1_done",   bus.done,  64'h2);
    chk("t1_rdata",     bus.rdata, 64'hDEADBEEF);
    chk("t1_noerr",     bus.err,   64'h0);
    cyc(); bus.req = '0; bus.ramstate = 2'b00;
    #1 chk("t1_after_gnt", bus.gnt, 64'h0);
    chk("t1_after_ren",    bus.ramREN, 64'h0);

    // T2: write by requester 2, ACCESS after one BUSY cycle
    bus.req = 4'b0100; bus.wen = 4'b0100;
    bus.wdata[2*32 +: 32] = 32'h1234; bus.addr[2*32 +: 32] = 32'h200;
    cyc(); bus.ramstate = 2'b01;
    #1 chk("t2_gnt",    bus.gnt,      64'h4);
    chk("t2_wen",       {bus.ramREN, bus.ramWEN}, 64'h1);
    chk("t2_store",     bus.ramstore, 64'h1234);
    chk("t2_addr",      bus.ramaddr,  64'h200);
    cyc(); bus.ramstate = 2'b10;
    #1 chk("t2_done",   bus.done, 64'h4);
    chk("t2_noerr",     bus.err,  64'h0);
    cyc(); bus.req = '0; bus.wen = '0; bus.ramstate = 2'b00;

    // T3: priority class vs. plain round-robin
    do_reset();
    bus.req = 4'b0011; bus0.req = 4'b0011;
    cyc(); bus.ramstate = 2'b10; bus0.ramstate = 2'b10;
    #1 chk("t3_first_gnt",   bus.gnt,  64'h2);
    chk("t3_first_done",     bus.done, 64'h2);
    chk("t3_np_first_gnt",   bus0.gnt, 64'h1);
    chk("t3_np_first_done",  bus0.done, 64'h1);
    cyc(); bus.req = 4'b0001; bus0.req = 4'b0010;
    #1 chk("t3_idle_gnt", {bus.gnt, bus0.gnt}, 64'h0);
    cyc();
    #1 chk("t3_second_gnt",  bus.gnt,  64'h1);
    chk("t3_second_done",    bus.done, 64'h1);
    chk("t3_np_second_gnt",  bus0.gnt, 64'h2);
    cyc(); idle_inputs();

    // T4: round robin within the priority class, immediate ACCESS
    do_reset();
    exp_gnt[0] = 4'b0000; exp_gnt[1] = 4'b0010;
    exp_gnt[2] = 4'b0000; exp_gnt[3] = 4'b1000;
    exp_gnt[4] = 4'b0000; exp_gnt[5] = 4'b0010;
    exp_gnt[6] = 4'b0000; exp_gnt[7] = 4'b1000;
    bus.req = 4'b1010; bus.ramstate = 2'b10;
    for (int i = 0; i < 8; i++) begin
      #1 chk($sformatf("t4_gnt_%0d", i), bus.gnt, 64'(exp_gnt[i]));
      cyc();
    end
    idle_inputs();

    // T5: watchdog abort on the 64th XFER cycle
    do_reset();
    bus.req = 4'b0101; bus.ramstate = 2'b01;
    cyc();
    for (int c = 1; c < 64; c++) begin
      if (c == 1 || c == 63) begin
        #1 chk($sformatf("t5_hold_%0d", c), {bus.gnt, bus.err}, {56'h0, 4'b0001, 4'b0000});
      end
      cyc();
    end
    #1 chk("t5_err",    bus.err,  64'h1);
    chk("t5_nodone",    bus.done, 64'h0);
    chk("t5_gnt_last",  bus.gnt,  64'h1);
    cyc(); bus.req = 4'b0100;
    #1 chk("t5_idle_gnt", bus.gnt, 64'h0);
    chk("t5_idle_err",    bus.err, 64'h0);
    cyc();
    #1 chk("t5_next_gnt", bus.gnt, 64'h4);
    bus.ramstate = 2'b10;
    cyc(); idle_inputs();

    // T6: RAM error, withdraw, reset mid-transfer
    do_reset();
    bus.req = 4'b0001;
    cyc(); bus.ramstate = 2'b11;
    #1 chk("t6_err",    bus.err,  64'h1);
    chk("t6_err_nodone", bus.done, 64'h0);
    cyc(); bus.req = 4'b1000; bus.ramstate = 2'b00;
    #1 chk("t6_idle_err", {bus.gnt, bus.err}, 64'h0);
    cyc(); bus.ramstate = 2'b01;
    #1 chk("t6_wd_gnt", bus.gnt, 64'h8);
    cyc(); bus.req = 4'b0000;
    #1 chk("t6_wd_nopulse", {bus.done, bus.err}, 64'h0);
    cyc();
    #1 chk("t6_wd_idle", {bus.gnt, 3'b000, bus.ramREN}, 64'h0);
    bus.req = 4'b0010; bus.ramstate = 2'b00;
    cyc(); bus.ramstate = 2'b10; rst = 1'b1;
    #1 chk("t6_rst_nodone", {bus.done, bus.err}, 64'h0);
    cyc();
    #1 chk("t6_rst_out", {bus.gnt, bus.done, bus.err, 3'b000, bus.ramREN}, 64'h0);
    chk("t6_rst_addr", bus.ramaddr, 64'h0);
    rst = 1'b0; bus.req = 4'b0101; bus.ramstate = 2'b00;
    cyc();
    #1 chk("t6_rr_zero", bus.gnt, 64'h1);
    idle_inputs();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
